exe_issue_ctrl: RTL
===================

EXE_ISSUE_CTRL -- requirements
Module: exe_issue_ctrl

Interface
REQ-001 SHALL have a single clock and reset pair:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.

REQ-002 SHALL have these decode-side ports:
- dec_valid  in  1  decode holds an op.
- dec_ready  out  1  controller accepts the op this edge.
- dec_opcode  in  opcode_t (10)  decoded opcode.
- dec_oprd1, dec_oprd2, dec_oprd3  in  64 each  operands.
- dec_next_rip  in  64  fall-through RIP.

REQ-003 SHALL have these ALU-side ports:
- alu_enable  out  1  drives the ALU enable.
- alu_opcode  out  opcode_t (10)  held opcode.
- alu_oprd1, alu_oprd2, alu_oprd3  out  64 each  held operands.
- alu_next_rip  out  64  held next RIP.
- alu_branch  in  1  registered branch flag from the ALU.
- alu_branch_rip  in  64  branch target from the ALU.

REQ-004 SHALL have these pipeline-side ports:
- mem_blocked  in  1  memory stage stalled.
- wb_idle  in  1  no op in flight in the mem or wb stages.
- flush  out  1  squash the front end.
- redirect_rip  out  64  fetch target, valid while flush=1.
- issue_cnt  out  32  ops consumed by the ALU.
- stall_cnt  out  32  cycles in ISSUE with mem_blocked=1.

Function
REQ-005 SHALL classify dec_opcode as follows:
- BRANCH: 10'b00_0111_????, 10'b00_1110_1011, 10'b01_1000_????, 10'b11_0001_0000.
- SERIAL: 10'b01_0000_0101.
- NORMAL: every other opcode.

REQ-006 SHALL use a four-state FSM: IDLE, DRAIN, ISSUE, RESOLVE.

REQ-007 SHALL capture all dec_* inputs into a holding register on any edge where dec_valid && dec_ready.

REQ-008 IDLE:
- alu_enable=0, dec_ready=1.
- On capture, a SERIAL op goes to DRAIN; any other op goes to ISSUE.

REQ-009 DRAIN:
- alu_enable=0, dec_ready=0.
- Goes to ISSUE on the first edge with wb_idle=1 && mem_blocked=0.

REQ-010 ISSUE:
- alu_enable=1.
- dec_ready = !mem_blocked && held class != BRANCH.

REQ-011 ISSUE with mem_blocked=1 SHALL hold state, the holding register and all alu_* outputs unchanged.

REQ-012 ISSUE with mem_blocked=0 means the op is consumed on that edge. Next state:
- RESOLVE if the held op is BRANCH;
- otherwise ISSUE or DRAIN if a new op is captured (by its class);
- otherwise IDLE.

REQ-013 RESOLVE SHALL last exactly one cycle with alu_enable=0 and dec_ready=0, then go to IDLE.

REQ-014 flush SHALL equal (state==RESOLVE && alu_branch); redirect_rip SHALL equal alu_branch_rip when flush=1 and 0 otherwise.

REQ-015 Back-to-back NORMAL ops SHALL sustain one consumed op per cycle with no bubble.

REQ-016 issue_cnt SHALL increment on each consumed op.

REQ-017 stall_cnt SHALL increment on each ISSUE cycle with mem_blocked=1.

REQ-018 Both counters SHALL wrap modulo 2^32 without saturation.

REQ-019 alu_* outputs SHALL always reflect the holding register, which is zero when IDLE after reset.

REQ-020 wb_idle and mem_blocked SHALL be ignored outside the states that reference them.

Reset
REQ-021 reset_n=0 at an edge SHALL force the following, from any state and dominating all simultaneous events:
- state=IDLE;
- holding register=0;
- issue_cnt=0, stall_cnt=0.

REQ-022 During and immediately after reset:
- alu_enable=0, flush=0, redirect_rip=0;
- dec_ready=1 in the first cycle after reset deasserts.

REQ-023 An op consumed on the same edge that reset asserts SHALL NOT increment issue_cnt.

Structure
REQ-024 Package exe_pkg SHALL hold:
- the state enum;
- the op-class enum (NORMAL, BRANCH, SERIAL);
- the function class_of(opcode_t).
opcode_t SHALL come from instruction.svh.

REQ-025 SHALL instantiate one sub-module, exe_op_class, a combinational opcode-to-class decoder, reused for both the dec_opcode and held-opcode paths.

REQ-026 The FSM, holding register and counters SHALL reside in exe_issue_ctrl; no other sub-modules.

Verification
REQ-027 SHALL cover these directed scenarios:
- Three NORMAL ops (0x01, 0x09, 0x89), dec_valid continuous, mem_blocked=0 -> alu_enable high 3 consecutive cycles; issue_cnt=3; dec_ready never low.
- NORMAL op 0x01, mem_blocked=1 for 4 cycles -> alu_* stable for 5 cycles; stall_cnt=4; issue_cnt=1 after release; dec_ready low while blocked.
- JMP 0x0EB, alu_branch=1, alu_branch_rip=0x401000 in RESOLVE -> one-cycle flush=1 with redirect_rip=0x401000; dec_ready=0 in the ISSUE and RESOLVE cycles.
- Jcc 0x074, alu_branch=0 -> RESOLVE one cycle, flush stays 0, IDLE next.
- syscall 0x105 with wb_idle=0 for 3 cycles, then 1 -> alu_enable=0 for 3 cycles; ISSUE on the edge wb_idle=1; only then does alu_enable rise.
- reset_n=0 mid-ISSUE with mem_blocked=1 and stall_cnt=7 -> next cycle IDLE, alu_enable=0, counters 0.
- Counter preset near wrap (force 0xFFFFFFFF), one consume -> issue_cnt=0.

Source files
------------

// File: rtl/exe_pkg.sv
// Execute issue types: FSM states, op classes, held-op record and opcode classifier.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package exe_pkg;

  `include "instruction.svh"

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    ISSUE   = 2'd2,
    RESOLVE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    BRANCH = 2'd1,
    SERIAL = 2'd2
  } op_class_t;

  // Everything the ALU needs for one op, latched together on capture.
  typedef struct packed {
    opcode_t     opcode;
    logic [63:0] oprd1;
    logic [63:0] oprd2;
    logic [63:0] oprd3;
    logic [63:0] next_rip;
  } hold_t;

  // BRANCH covers Jcc short/near, JMP rel8 and the far/indirect group;
  // SERIAL is syscall, which must wait for the back end to empty.
  function automatic op_class_t class_of(input opcode_t op);
    op_class_t cls;
    casez (op)
      10'b00_0111_????,
      10'b00_1110_1011,
      10'b01_1000_????,
      10'b11_0001_0000: cls = BRANCH;
      10'b01_0000_0101: cls = SERIAL;
      default:          cls = NORMAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/exe_op_class.sv
// Combinational opcode-to-class decoder.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
// Ports: opcode (in, opcode_t), op_class (out, op_class_t).
module exe_op_class
  import exe_pkg::*;
(
  input  opcode_t   opcode,
  output op_class_t op_class
);

  assign op_class = class_of(opcode);

endmodule

// File: rtl/instruction.svh
// Shared instruction-level types for the execute cluster.
//   opcode_t : 10-bit decoded opcode as produced by the decoder.
`ifndef INSTRUCTION_SVH
`define INSTRUCTION_SVH

typedef logic [9:0] opcode_t;

`endif

// File: rtl/exe_issue_ctrl.sv
// Issue controller between decode and the ALU: holds one op, serialises syscalls, resolves branches.
// Latency: captured op drives the ALU the cycle after capture; back-to-back NORMAL ops issue every cycle.
// Backpressure: dec_ready drops while mem_blocked, in DRAIN/RESOLVE, and while a branch sits in ISSUE.
// Ports: clk/reset_n (sync active-low); dec_* op handshake in; alu_* held op out, alu_branch* in;
//        mem_blocked/wb_idle pipeline status in; flush/redirect_rip out; issue_cnt/stall_cnt counters out.
module exe_issue_ctrl
  import exe_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,

  input  logic        dec_valid,
  output logic        dec_ready,
  input  opcode_t     dec_opcode,
  input  logic [63:0] dec_oprd1,
  input  logic [63:0] dec_oprd2,
  input  logic [63:0] dec_oprd3,
  input  logic [63:0] dec_next_rip,

  output logic        alu_enable,
  output opcode_t     alu_opcode,
  output logic [63:0] alu_oprd1,
  output logic [63:0] alu_oprd2,
  output logic [63:0] alu_oprd3,
  output logic [63:0] alu_next_rip,
  input  logic        alu_branch,
  input  logic [63:0] alu_branch_rip,

  input  logic        mem_blocked,
  input  logic        wb_idle,
  output logic        flush,
  output logic [63:0] redirect_rip,
  output logic [31:0] issue_cnt,
  output logic [31:0] stall_cnt
);

  state_t      state_q, state_d;
  hold_t       hold_q;
  logic [31:0] issue_cnt_q;
  logic [31:0] stall_cnt_q;

  op_class_t   dec_cls;
  op_class_t   hold_cls;
  logic        capture;
  logic        consume;
  logic        stall;

  // Same decoder serves the incoming op (next-state choice) and the held op
  // (branch back-pressure and RESOLVE entry).
  exe_op_class u_dec_class (
    .opcode   (dec_opcode),
    .op_class (dec_cls)
  );

  exe_op_class u_hold_class (
    .opcode   (hold_q.opcode),
    .op_class (hold_cls)
  );

  assign capture = dec_valid && dec_ready;
  assign consume = (state_q == ISSUE) && !mem_blocked;
  assign stall   = (state_q == ISSUE) &&  mem_blocked;

  always_comb begin
    state_d    = state_q;
    alu_enable = 1'b0;
    dec_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        dec_ready = 1'b1;
        if (dec_valid) begin
          state_d = (dec_cls == SERIAL) ? DRAIN : ISSUE;
        end
      end
      DRAIN: begin
        if (wb_idle && !mem_blocked) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        alu_enable = 1'b1;
        // A branch must resolve before anything younger is accepted.
        dec_ready  = !mem_blocked && (hold_cls != BRANCH);
        if (!mem_blocked) begin
          if (hold_cls == BRANCH) begin
            state_d = RESOLVE;
          end else if (dec_valid) begin
            state_d = (dec_cls == SERIAL) ? DRAIN : ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      RESOLVE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        hold_q.opcode   <= dec_opcode;
        hold_q.oprd1    <= dec_oprd1;
        hold_q.oprd2    <= dec_oprd2;
        hold_q.oprd3    <= dec_oprd3;
        hold_q.next_rip <= dec_next_rip;
      end
      if (consume) begin
        issue_cnt_q <= issue_cnt_q + 32'd1;
      end
      if (stall) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign alu_opcode   = hold_q.opcode;
  assign alu_oprd1    = hold_q.oprd1;
  assign alu_oprd2    = hold_q.oprd2;
  assign alu_oprd3    = hold_q.oprd3;
  assign alu_next_rip = hold_q.next_rip;

  assign flush        = (state_q == RESOLVE) && alu_branch;
  assign redirect_rip = flush ? alu_branch_rip : 64'd0;

  assign issue_cnt    = issue_cnt_q;
  assign stall_cnt    = stall_cnt_q;

endmodule
